// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared loader FSM states and constants
package loader_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam int PU_LAT     = 2;
    localparam int GROUP_SIZE = 4;
    localparam int SLOT_W     = $clog2(GROUP_SIZE);

endpackage

// File: rtl/valid_delay.sv
// rtl/valid_delay.sv - fixed-depth shift line for a single valid bit
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                shift_q[i] <= shift_q[i-1];
            end
        end
    end

    assign valid_o = shift_q[DEPTH-1];

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - gathers serial beats into 4-operand groups for the processing unit
// Optional partial-group flush port enabled by OPERAND_LOADER_FLUSH_EN.
module operand_loader
    import loader_pkg::*;
#(
    parameter int XLEN = 5,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            hold,
`ifdef OPERAND_LOADER_FLUSH_EN
    input  logic            flush,
`endif
    output logic [XLEN-1:0] num1,
    output logic [XLEN-1:0] num2,
    output logic [XLEN-1:0] num3,
    output logic [XLEN-1:0] num4,
    output logic            issue,
    output logic            result_valid,
    output logic [CNTW-1:0] grp_cnt
);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]   slot_q [GROUP_SIZE];
    logic [XLEN-1:0]   slot_d [GROUP_SIZE];
    logic [XLEN-1:0]   num_q  [GROUP_SIZE];
    logic              issue_q;
    logic [CNTW-1:0]   grp_cnt_q;
    logic              accept;
    logic              copy;
    logic              flush_req;

`ifdef OPERAND_LOADER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Ready never looks at in_valid, so upstream can drive valid from ready safely.
    assign in_ready = !rst && ((state_q == FILL) || !hold);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        copy    = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    slot_d[cnt_q] = in_data;
                    cnt_d         = cnt_q + 1'b1;
                end
                if (accept && (cnt_q == SLOT_W'(GROUP_SIZE - 1))) begin
                    state_d = ISSUE;
                end else if (flush_req && (accept || (cnt_q != '0))) begin
                    for (int k = 0; k < GROUP_SIZE; k++) begin
                        if (k >= int'(cnt_q) + int'(accept)) begin
                            slot_d[k] = '0;
                        end
                    end
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    copy    = 1'b1;
                    state_d = FILL;
                    cnt_d   = '0;
                    // The release cycle already accepts slot 0 of the next group.
                    if (accept) begin
                        slot_d[0] = in_data;
                        cnt_d     = SLOT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            issue_q   <= 1'b0;
            grp_cnt_q <= '0;
            for (int k = 0; k < GROUP_SIZE; k++) begin
                slot_q[k] <= '0;
                num_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            issue_q <= copy;
            slot_q  <= slot_d;
            if (copy) begin
                num_q     <= slot_q;
                grp_cnt_q <= grp_cnt_q + CNTW'(1);
            end
        end
    end

    valid_delay #(
        .DEPTH(PU_LAT)
    ) u_result_delay (
        .clk    (clk),
        .rst    (rst),
        .valid_i(issue_q),
        .valid_o(result_valid)
    );

    assign num1    = num_q[0];
    assign num2    = num_q[1];
    assign num3    = num_q[2];
    assign num4    = num_q[3];
    assign issue   = issue_q;
    assign grp_cnt = grp_cnt_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - scoreboard bench for operand_loader with a queue-based reference model
module tb_operand_loader;

    localparam int XLEN = 5;
    localparam int CNTW = 2;
`ifdef OPERAND_LOADER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic [XLEN-1:0] in_data  = '0;
    logic            in_valid = 1'b0;
    logic            hold     = 1'b0;
    logic            flush    = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] num1, num2, num3, num4;
    logic            issue;
    logic            result_valid;
    logic [CNTW-1:0] grp_cnt;

    operand_loader #(
        .XLEN(XLEN),
        .CNTW(CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .hold        (hold),
`ifdef OPERAND_LOADER_FLUSH_EN
        .flush       (flush),
`endif
        .num1        (num1),
        .num2        (num2),
        .num3        (num3),
        .num4        (num4),
        .issue       (issue),
        .result_valid(result_valid),
        .grp_cnt     (grp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][XLEN-1:0] n;
        int                   grp;
        int                   cyc;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [XLEN-1:0]      cur[$];
    logic [3:0][XLEN-1:0] held;
    bit                   full  = 1'b0;
    int                   m_grp = 0;
    exp_t                 exp_q[$];
    int                   rv_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic release_group();
        exp_t e;
        m_grp = (m_grp + 1) % (1 << CNTW);
        e.n   = held;
        e.grp = m_grp;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        rv_q.push_back(cyc + 3);
        full = 1'b0;
    endtask

    task automatic step(bit v, logic [XLEN-1:0] d, bit h, bit f);
        bit ready;
        bit acc;
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        hold     = h;
        flush    = f;
        @(negedge clk);
        ready = !full || !h;
        check("in_ready", in_ready, ready);
        acc = v && ready;
        if (full) begin
            if (!h) release_group();
            if (acc) cur.push_back(d);
        end else begin
            if (acc) cur.push_back(d);
            if (cur.size() == 4) begin
                for (int k = 0; k < 4; k++) held[k] = cur[k];
                cur.delete();
                full = 1'b1;
            end else if (FLUSH_EN && f && cur.size() > 0) begin
                for (int k = 0; k < 4; k++) held[k] = (k < cur.size()) ? cur[k] : '0;
                cur.delete();
                full = 1'b1;
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        cur.delete();
        full  = 1'b0;
        m_grp = 0;
        exp_q.delete();
        rv_q.delete();
        #1;
        check("rst_num1", num1, 0);
        check("rst_num2", num2, 0);
        check("rst_num3", num3, 0);
        check("rst_num4", num4, 0);
        check("rst_issue", issue, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_grp_cnt", grp_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);
    endtask

    // Monitor: compares every cycle against the scoreboard queues.
    logic [3:0][XLEN-1:0] mon_num = '0;
    int                   mon_grp = 0;
    initial begin
        exp_t e;
        bit   exp_issue;
        bit   exp_rv;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_num = '0;
                mon_grp = 0;
            end else begin
                exp_issue = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e         = exp_q.pop_front();
                    mon_num   = e.n;
                    mon_grp   = e.grp;
                    exp_issue = 1'b1;
                end
                check("issue", issue, exp_issue);
                check("num1", num1, mon_num[0]);
                check("num2", num2, mon_num[1]);
                check("num3", num3, mon_num[2]);
                check("num4", num4, mon_num[3]);
                check("grp_cnt", grp_cnt, mon_grp);
                exp_rv = 1'b0;
                if (rv_q.size() > 0 && rv_q[0] == cyc) begin
                    void'(rv_q.pop_front());
                    exp_rv = 1'b1;
                end
                check("result_valid", result_valid, exp_rv);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        do_reset();

        // Directed group 3,7,12,31.
        step(1, 5'd3, 0, 0);
        step(1, 5'd7, 0, 0);
        step(1, 5'd12, 0, 0);
        step(1, 5'd31, 0, 0);
        idle(5);

        // Full group stalled by hold for 5 cycles, with upstream still offering data.
        for (int i = 0; i < 4; i++) step(1, XLEN'($urandom), 0, 0);
        for (int i = 0; i < 5; i++) step(1, XLEN'($urandom), 1, 0);
        idle(5);

        // Back-to-back stream of 8 beats.
        for (int i = 0; i < 8; i++) step(1, XLEN'(i + 20), 0, 0);
        idle(5);

        // Reset with a partial group, then a fresh group.
        step(1, 5'd1, 0, 0);
        step(1, 5'd2, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, XLEN'(i + 10), 0, 0);
        idle(5);

        // Five groups to walk grp_cnt through its wrap.
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 4; i++) step(1, XLEN'($urandom), 0, 0);
        end
        idle(5);

        if (FLUSH_EN) begin
            do_reset();
            step(1, 5'd5, 0, 0);
            step(1, 5'd9, 0, 0);
            step(0, '0, 0, 1);
            idle(5);
            step(0, '0, 0, 1);
            idle(5);
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, XLEN'($urandom), ($urandom % 3) == 0,
                 FLUSH_EN && (($urandom % 8) == 0));
        end
        idle(8);

        check("pending_issues", exp_q.size(), 0);
        check("pending_results", rv_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter XLEN, default 5: width of each operand and of the input sample.
REQ-002 SHALL have parameter CNTW, default 8: width of the issued-group counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_data  input  XLEN  serial operand sample.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  loader accepts a beat this cycle.
REQ-008 SHALL have port hold  input  1  downstream processing unit stall request; blocks issue.
REQ-009 SHALL have ports num1, num2, num3, num4  output  XLEN each  registered operand group driving the processing unit.
REQ-010 SHALL have port issue  output  1  one-cycle pulse in the first cycle a new group is present on num1..num4.
REQ-011 SHALL have port result_valid  output  1  processing-unit result for the group is valid this cycle.
REQ-012 SHALL have port grp_cnt  output  CNTW  number of groups issued, modulo 2^CNTW.

Function
REQ-013 SHALL accept a beat when in_valid and in_ready are both 1 in the same cycle.
REQ-014 SHALL store accepted beats, in order, into fill slots 0..3; slot k maps to num(k+1).
REQ-015 SHALL implement FSM state FILL: slot count 0..3, in_ready=1; on the 4th accepted beat, go to ISSUE.
REQ-016 SHALL implement FSM state ISSUE with hold=1: stay in ISSUE, in_ready=0, num1..num4 unchanged.
REQ-017 SHALL, in FSM state ISSUE with hold=0, copy all four slots to num1..num4 at the clock edge, clear the slot count, set in_ready=1, and go to FILL.
REQ-018 SHALL, when a beat is accepted in the issue cycle, store it as slot 0 of the next group (no bubble).
REQ-019 SHALL assert issue for exactly one cycle, the cycle after the copy edge; num1..num4 SHALL hold until the next copy.
REQ-020 SHALL assert result_valid exactly PU_LAT=2 cycles after issue (processing unit input register plus output register), as a 2-stage shift of issue.
REQ-021 SHALL increment grp_cnt by 1 at each copy edge and wrap from 2^CNTW-1 to 0.
REQ-022 SHALL have no combinational path from in_valid to in_ready; in_ready SHALL depend on state and hold only.

Reset
REQ-023 SHALL, while rst=1, asynchronously force: state FILL, slot count 0, slots 0, num1..num4 0, issue 0, result_valid pipeline 0, grp_cnt 0, in_ready 0.
REQ-024 SHALL discard a partial group and any in-flight result_valid when reset asserts mid-operation; in_ready SHALL return to 1 in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with macro OPERAND_LOADER_FLUSH_EN defined, add port flush  input  1.
REQ-026 SHALL, with flush=1 in FILL, take a same-cycle beat first, zero-pad the remaining slots, and go to ISSUE; flush with an empty group and no beat SHALL be ignored; flush SHALL be ignored in ISSUE.
REQ-027 SHALL, without the macro, have no flush port; groups SHALL issue only when full.

Structure
REQ-028 SHALL place the FSM state enumeration typedef (FILL, ISSUE) and the constants PU_LAT=2 and GROUP_SIZE=4 in shared package loader_pkg.
REQ-029 SHALL implement the result_valid delay line as sub-module valid_delay, parameterised by depth.

Verification
REQ-030 Bench SHALL cover: beats 3,7,12,31 with hold=0 -> num1..num4=3,7,12,31; issue one cycle; result_valid 2 cycles later; grp_cnt=1.
REQ-031 Bench SHALL cover: group full with hold=1 for 5 cycles -> in_ready=0, num1..num4 unchanged, no issue; issue in the cycle after hold drops.
REQ-032 Bench SHALL cover: back-to-back stream of 8 beats with in_valid constantly 1 -> two issues exactly 4 cycles apart, no dropped beat.
REQ-033 Bench SHALL cover: rst asserted after 2 beats -> all outputs 0 immediately; next 4 beats form a fresh group.
REQ-034 Bench SHALL cover: with CNTW=2, 5 groups issued -> grp_cnt sequence 1,2,3,0,1.
REQ-035 Bench SHALL cover, with OPERAND_LOADER_FLUSH_EN defined: beats 5,9 then flush -> num1..num4=5,9,0,0; flush with an empty group -> no issue.
